// File: rtl/trap_ctrl_pkg.sv
// Shared definitions for the machine-mode trap controller: FSM states,
// request codes, CSR addresses and mstatus field positions.
package trap_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_EPC,
        ST_WR_CAUSE,
        ST_RD_STATUS,
        ST_WR_STATUS,
        ST_RD_VEC,
        ST_RD_EPC,
        ST_REDIRECT
    } state_e;

    localparam logic [1:0] REQ_RSVD  = 2'b00;
    localparam logic [1:0] REQ_ECALL = 2'b01;
    localparam logic [1:0] REQ_MRET  = 2'b10;
    localparam logic [1:0] REQ_EXC   = 2'b11;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

endpackage

// File: rtl/trap_ctrl_mstatus_update.sv
// Combinational mstatus rewrite for trap entry (is_ret=0) and mret (is_ret=1).
module mstatus_update
    import trap_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] old_val,
    input  logic                  is_ret,
    output logic [DATA_WIDTH-1:0] new_val
);

    always_comb begin
        new_val = old_val;
        if (is_ret) begin
            new_val[MSTATUS_MIE]                   = old_val[MSTATUS_MPIE];
            new_val[MSTATUS_MPIE]                  = 1'b1;
            new_val[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b00;
        end else begin
            new_val[MSTATUS_MPIE]                  = old_val[MSTATUS_MIE];
            new_val[MSTATUS_MIE]                   = 1'b0;
            new_val[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        end
    end

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap controller: sequences the CSR accesses for ecall,
// synchronous exceptions and mret, then issues a one-cycle fetch redirect.
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [1:0]            req_type,
    input  logic [DATA_WIDTH-1:0] req_pc,
    input  logic [DATA_WIDTH-1:0] req_cause,
    output logic                  csr_we,
    output logic                  csr_re,
    output logic [11:0]           csr_addr,
    output logic [DATA_WIDTH-1:0] csr_wdata,
    input  logic [DATA_WIDTH-1:0] csr_rdata,
    output logic                  redir_valid,
    output logic [DATA_WIDTH-1:0] redir_pc,
    output logic                  busy
);

    state_e                state_q, state_d;
    logic [1:0]            type_q, type_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] cause_q, cause_d;
    logic [DATA_WIDTH-1:0] status_q, status_d;
    logic [DATA_WIDTH-1:0] target_q, target_d;
    logic [DATA_WIDTH-1:0] status_new;
    logic                  hs;

    assign req_ready = (state_q == ST_IDLE);
    assign hs        = req_valid && req_ready && (req_type != REQ_RSVD);

    mstatus_update #(.DATA_WIDTH(DATA_WIDTH)) u_mstatus_update (
        .old_val (status_q),
        .is_ret  (type_q == REQ_MRET),
        .new_val (status_new)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            type_q   <= '0;
            pc_q     <= '0;
            cause_q  <= '0;
            status_q <= '0;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            type_q   <= type_d;
            pc_q     <= pc_d;
            cause_q  <= cause_d;
            status_q <= status_d;
            target_q <= target_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (hs) state_d = (req_type == REQ_MRET) ? ST_RD_STATUS : ST_WR_EPC;
            ST_WR_EPC:    state_d = ST_WR_CAUSE;
            ST_WR_CAUSE:  state_d = ST_RD_STATUS;
            ST_RD_STATUS: state_d = ST_WR_STATUS;
            ST_WR_STATUS: state_d = (type_q == REQ_MRET) ? ST_RD_EPC : ST_RD_VEC;
            ST_RD_VEC:    state_d = ST_REDIRECT;
            ST_RD_EPC:    state_d = ST_REDIRECT;
            ST_REDIRECT:  state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    // Request fields are captured only on a handshake, so the core may
    // change them freely while the sequence runs.
    always_comb begin
        type_d   = type_q;
        pc_d     = pc_q;
        cause_d  = cause_q;
        status_d = status_q;
        target_d = target_q;
        if (state_q == ST_IDLE && hs) begin
            type_d  = req_type;
            pc_d    = req_pc;
            cause_d = req_cause;
        end
        if (state_q == ST_RD_STATUS) status_d = csr_rdata;
        if (state_q == ST_RD_VEC || state_q == ST_RD_EPC)
            target_d = {csr_rdata[DATA_WIDTH-1:2], 2'b00};
    end

    always_comb begin
        csr_we      = 1'b0;
        csr_re      = 1'b0;
        csr_addr    = '0;
        csr_wdata   = '0;
        redir_valid = 1'b0;
        redir_pc    = '0;
        busy        = (state_q != ST_IDLE);
        case (state_q)
            ST_WR_EPC: begin
                csr_we    = 1'b1;
                csr_addr  = CSR_MEPC;
                csr_wdata = (type_q == REQ_ECALL) ? pc_q + DATA_WIDTH'(4) : pc_q;
            end
            ST_WR_CAUSE: begin
                csr_we    = 1'b1;
                csr_addr  = CSR_MCAUSE;
                csr_wdata = cause_q;
            end
            ST_RD_STATUS: begin
                csr_re   = 1'b1;
                csr_addr = CSR_MSTATUS;
            end
            ST_WR_STATUS: begin
                csr_we    = 1'b1;
                csr_addr  = CSR_MSTATUS;
                csr_wdata = status_new;
            end
            ST_RD_VEC: begin
                csr_re   = 1'b1;
                csr_addr = CSR_MTVEC;
            end
            ST_RD_EPC: begin
                csr_re   = 1'b1;
                csr_addr = CSR_MEPC;
            end
            ST_REDIRECT: begin
                redir_valid = 1'b1;
                redir_pc    = target_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// Bench for trap_ctrl: a behavioural CSR file plus a scoreboard of expected
// CSR writes, with per-scenario tasks checking latency and redirect targets.
module tb_trap_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_type = 2'b00;
    logic [31:0] req_pc = '0;
    logic [31:0] req_cause = '0;
    logic        csr_we, csr_re;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        redir_valid;
    logic [31:0] redir_pc;
    logic        busy;

    int vectors = 0;
    int errors  = 0;

    typedef struct packed {
        logic [11:0] addr;
        logic [31:0] data;
    } wr_t;
    wr_t exp_q[$];

    logic [31:0] m_mstatus, m_mtvec, m_mepc, m_mcause;

    trap_ctrl #(.DATA_WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_type    (req_type),
        .req_pc      (req_pc),
        .req_cause   (req_cause),
        .csr_we      (csr_we),
        .csr_re      (csr_re),
        .csr_addr    (csr_addr),
        .csr_wdata   (csr_wdata),
        .csr_rdata   (csr_rdata),
        .redir_valid (redir_valid),
        .redir_pc    (redir_pc),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always_comb begin
        csr_rdata = 32'h0;
        case (csr_addr)
            12'h300: csr_rdata = m_mstatus;
            12'h305: csr_rdata = m_mtvec;
            12'h341: csr_rdata = m_mepc;
            12'h342: csr_rdata = m_mcause;
            default: csr_rdata = 32'h0;
        endcase
    end

    always @(posedge clk) begin
        if (rst_n && csr_we) begin
            case (csr_addr)
                12'h300: m_mstatus <= csr_wdata;
                12'h305: m_mtvec   <= csr_wdata;
                12'h341: m_mepc    <= csr_wdata;
                12'h342: m_mcause  <= csr_wdata;
                default: ;
            endcase
        end
    end

    // Scoreboard: every observed CSR write must match the head of exp_q.
    always @(negedge clk) begin
        if (rst_n) begin
            if (csr_we && csr_re) begin
                vectors++; errors++;
                $display("FAIL we_re_excl: csr_we=%b csr_re=%b required not both", csr_we, csr_re);
            end
            if (csr_we) begin
                wr_t e;
                vectors++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: addr=%h data=%h required no write", csr_addr, csr_wdata);
                end else begin
                    e = exp_q.pop_front();
                    if (csr_addr !== e.addr || csr_wdata !== e.data) begin
                        errors++;
                        $display("FAIL csr_write: addr=%h data=%h required addr=%h data=%h",
                                 csr_addr, csr_wdata, e.addr, e.data);
                    end
                end
            end
        end
    end

    task automatic push_wr(input logic [11:0] a, input logic [31:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Present a request at a negedge, then count cycles to the redirect.
    task automatic issue(input logic [1:0] t, input logic [31:0] pc, input logic [31:0] cause,
                         input bit hold, output int cyc);
        @(negedge clk);
        req_valid = 1'b1;
        req_type  = t;
        req_pc    = pc;
        req_cause = cause;
        @(posedge clk);
        if (!hold) begin
            #1;
            req_valid = 1'b0;
            req_pc    = $urandom;
            req_cause = $urandom;
        end
        cyc = 0;
        while (cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (redir_valid) break;
        end
        req_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #12;
        vectors++;
        if ({req_ready, busy, redir_valid, csr_we, csr_re} !== 5'b10000 || redir_pc !== 32'h0
            || csr_addr !== 12'h0 || csr_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: rdy=%b busy=%b rv=%b we=%b re=%b rpc=%h required 1 0 0 0 0 0",
                     req_ready, busy, redir_valid, csr_we, csr_re, redir_pc);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_ecall;
        int cyc;
        m_mstatus = 32'h8;
        m_mtvec   = 32'h80000101;
        push_wr(12'h341, 32'h80000014);
        push_wr(12'h342, 32'd11);
        push_wr(12'h300, 32'h1880);
        vectors++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL ecall_ready: got %b required 1", req_ready);
        end
        issue(2'b01, 32'h80000010, 32'd11, 1'b0, cyc);
        vectors++;
        if (cyc != 6 || redir_pc !== 32'h80000100) begin
            errors++;
            $display("FAIL ecall_redirect: cycle=%0d pc=%h required cycle=6 pc=80000100", cyc, redir_pc);
        end
        @(negedge clk);
        vectors++;
        if (req_ready !== 1'b1 || busy !== 1'b0 || redir_valid !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL ecall_done: rdy=%b busy=%b rv=%b pending=%0d required 1 0 0 0",
                     req_ready, busy, redir_valid, exp_q.size());
        end
    endtask

    task automatic test_mret;
        int cyc;
        push_wr(12'h300, 32'h88);
        issue(2'b10, 32'h12345678, 32'hdeadbeef, 1'b0, cyc);
        vectors++;
        if (cyc != 4 || redir_pc !== 32'h80000014) begin
            errors++;
            $display("FAIL mret_redirect: cycle=%0d pc=%h required cycle=4 pc=80000014", cyc, redir_pc);
        end
        @(negedge clk);
        vectors++;
        if (req_ready !== 1'b1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL mret_done: rdy=%b pending=%0d required 1 0", req_ready, exp_q.size());
        end
    endtask

    task automatic test_exception;
        int cyc;
        push_wr(12'h341, 32'h80000020);
        push_wr(12'h342, 32'd2);
        push_wr(12'h300, 32'h1880);
        issue(2'b11, 32'h80000020, 32'd2, 1'b0, cyc);
        vectors++;
        if (cyc != 6 || redir_pc !== 32'h80000100) begin
            errors++;
            $display("FAIL exc_redirect: cycle=%0d pc=%h required cycle=6 pc=80000100", cyc, redir_pc);
        end
        @(negedge clk);
        vectors++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL exc_pending: got %0d required 0", exp_q.size());
        end
    endtask

    task automatic test_reserved;
        @(negedge clk);
        req_valid = 1'b1;
        req_type  = 2'b00;
        req_pc    = 32'h1000;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vectors++;
            if (busy !== 1'b0 || csr_we !== 1'b0 || csr_re !== 1'b0 || req_ready !== 1'b1) begin
                errors++;
                $display("FAIL reserved_idle: busy=%b we=%b re=%b rdy=%b required 0 0 0 1",
                         busy, csr_we, csr_re, req_ready);
            end
        end
        req_valid = 1'b0;
    endtask

    task automatic test_reset_mid;
        push_wr(12'h341, 32'h80000044);
        push_wr(12'h342, 32'd11);
        @(negedge clk);
        req_valid = 1'b1;
        req_type  = 2'b01;
        req_pc    = 32'h80000040;
        req_cause = 32'd11;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        vectors++;
        if ({busy, redir_valid, csr_we, csr_re} !== 4'b0000 || redir_pc !== 32'h0
            || csr_addr !== 12'h0 || csr_wdata !== 32'h0) begin
            errors++;
            $display("FAIL midreset_outputs: busy=%b rv=%b we=%b re=%b addr=%h required all 0",
                     busy, redir_valid, csr_we, csr_re, csr_addr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_ready: rdy=%b busy=%b required 1 0", req_ready, busy);
        end
        repeat (8) @(negedge clk);
        vectors++;
        if (m_mstatus !== 32'h1880 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL midreset_nowrite: mstatus=%h pending=%0d required 1880 0", m_mstatus, exp_q.size());
        end
    endtask

    task automatic test_back_to_back;
        int cyc;
        push_wr(12'h341, 32'h00000000);
        push_wr(12'h342, 32'd11);
        push_wr(12'h300, 32'h1800);
        issue(2'b01, 32'hFFFFFFFC, 32'd11, 1'b1, cyc);
        vectors++;
        if (cyc != 6 || redir_pc !== 32'h80000100) begin
            errors++;
            $display("FAIL wrap_redirect: cycle=%0d pc=%h required cycle=6 pc=80000100", cyc, redir_pc);
        end
        repeat (3) begin
            @(negedge clk);
            vectors++;
            if (busy !== 1'b0 || req_ready !== 1'b1) begin
                errors++;
                $display("FAIL single_accept: busy=%b rdy=%b required 0 1", busy, req_ready);
            end
        end
        vectors++;
        if (exp_q.size() != 0 || m_mepc !== 32'h0) begin
            errors++;
            $display("FAIL wrap_mepc: mepc=%h pending=%0d required 0 0", m_mepc, exp_q.size());
        end
    endtask

    initial begin
        m_mstatus = '0;
        m_mtvec   = '0;
        m_mepc    = '0;
        m_mcause  = '0;
        test_reset();
        test_ecall();
        test_mret();
        test_exception();
        test_reserved();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/trap_ctrl.md
TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of CSR data, PC and cause.
REQ-002 SHALL have port clk, input, 1, the single clock; all state on rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port req_valid, input, 1, core presents a trap/return request.
REQ-005 SHALL have port req_ready, output, 1, controller accepts the request this cycle.
REQ-006 SHALL have port req_type, input, 2: 01 ecall, 10 mret, 11 synchronous exception, 00 reserved.
REQ-007 SHALL have port req_pc, input, DATA_WIDTH, PC of the trapping instruction.
REQ-008 SHALL have port req_cause, input, DATA_WIDTH, mcause value, used for ecall/exception.
REQ-009 SHALL have ports csr_we and csr_re, output, 1 each, CSR file write and read enables.
REQ-010 SHALL have port csr_addr, output, 12, CSR address (0x341 mepc, 0x342 mcause, 0x300 mstatus, 0x305 mtvec).
REQ-011 SHALL have ports csr_wdata, output, DATA_WIDTH, and csr_rdata, input, DATA_WIDTH (combinational read, same cycle).
REQ-012 SHALL have ports redir_valid, output, 1, and redir_pc, output, DATA_WIDTH, one-cycle fetch redirect.
REQ-013 SHALL have port busy, output, 1, high in every non-IDLE state.

Function
REQ-014 SHALL assert req_ready only in IDLE; a handshake is req_valid && req_ready with req_type != 00.
REQ-015 SHALL ignore a valid request with req_type 00: remain IDLE, no CSR access.
REQ-016 SHALL latch req_type, req_pc, req_cause at handshake; inputs thereafter do not matter until IDLE.
REQ-017 SHALL sequence ecall/exception: IDLE -> WR_EPC -> WR_CAUSE -> RD_STATUS -> WR_STATUS -> RD_VEC -> REDIRECT -> IDLE, one cycle per state.
REQ-018 SHALL sequence mret: IDLE -> RD_STATUS -> WR_STATUS -> RD_EPC -> REDIRECT -> IDLE.
REQ-019 WR_EPC SHALL write 0x341 with req_pc+4 for ecall and req_pc for exception, modulo 2^DATA_WIDTH.
REQ-020 WR_CAUSE SHALL write 0x342 with latched req_cause.
REQ-021 RD_STATUS SHALL read 0x300 and register csr_rdata; WR_STATUS SHALL write that value modified.
REQ-022 Trap entry mstatus: bit7 (MPIE) <= old bit3 (MIE), bit3 <= 0, bits12:11 (MPP) <= 11; other bits unchanged.
REQ-023 mret mstatus: bit3 <= old bit7, bit7 <= 1, bits12:11 <= 00; other bits unchanged.
REQ-024 RD_VEC/RD_EPC SHALL read 0x305/0x341 and register the target, low two bits forced to 0.
REQ-025 REDIRECT SHALL drive redir_valid=1 with redir_pc = registered target for exactly one cycle.
REQ-026 csr_we, csr_re SHALL never be high together; outside write/read states both 0, csr_addr 0, csr_wdata 0.
REQ-027 Latency: ecall/exception redirect 6 cycles after handshake edge, mret 4; req_ready high the cycle after REDIRECT.
REQ-028 Back-to-back requests SHALL be accepted only from IDLE; no request queued.

Reset
REQ-029 rst_n low SHALL force IDLE, redir_valid=0, redir_pc=0, csr_we=0, csr_re=0, busy=0, latched registers 0, asynchronously.
REQ-030 Reset mid-sequence SHALL abandon it; no further CSR write occurs after rst_n deasserts; req_ready=1 first cycle after release.

Structure
REQ-031 State encoding, req_type codes, CSR addresses and mstatus bit positions SHALL live in a shared package.
REQ-032 mstatus update SHALL be a combinational sub-module mstatus_update (inputs old value, entry/return select).

Verification
REQ-033 ecall pc=0x80000010, cause=11, mstatus=0x8, mtvec=0x80000101 -> writes mepc=0x80000014, mcause=11, mstatus=0x1880; redir_pc=0x80000100 at cycle 6.
REQ-034 mret with mstatus=0x1880, mepc=0x80000014 -> mstatus write 0x88; redir_pc=0x80000014 at cycle 4.
REQ-035 exception pc=0x80000020, cause=2 -> mepc write 0x80000020, mcause write 2.
REQ-036 req_type=00 with req_valid=1 for 5 cycles -> no csr_we/csr_re, busy=0.
REQ-037 rst_n low during WR_STATUS -> no mstatus write, all outputs 0, req_ready=1 after release.
REQ-038 req_pc=0xFFFFFFFC ecall -> mepc write 0x00000000; req_valid held high during sequence -> single acceptance.
